matrix_load_seq: RTL and testbench

- Producer-side loader for the sequential matrix multiplier.
- Accepts a serial stream of M-bit elements over a valid/ready handshake and assembles them row-major into the two flat N*N operand buses x and y, which feed the multiplier directly.
- Signals when both operands are complete, then holds them stable until the consumer releases the buffer.

---
 rtl/matrix_load_seq.sv | 82 ++++++++
 tb/tb_matrix_load_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_load_seq.sv
// Serial element loader for the sequential matrix multiplier: assembles two
// row-major N x N operands from a valid/ready stream and holds them until cleared.
//
// state  | meaning
// LOAD_X | accepting elements into operand x
// LOAD_Y | accepting elements into operand y
// FULL   | both operands complete, held stable until clear
module matrix_load_seq #(
  parameter int N = 3,
  parameter int M = 32,
  localparam int CW = $clog2(2*N*N + 1),
  localparam int RW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic [M*N*N-1:0]  x,
  output logic [M*N*N-1:0]  y,
  output logic              loaded,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    FULL   = 2'd2
  } state_t;

  localparam logic [RW-1:0] LAST = RW'(N - 1);

  state_t        state;
  logic [RW-1:0] r;
  logic [RW-1:0] c;
  int            idx;

  // Ready is forced low while reset is held so nothing is offered into a reset load.
  assign in_ready = rst && (state != FULL);
  assign idx      = N * int'(r) + int'(c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= LOAD_X;
      r      <= '0;
      c      <= '0;
      count  <= '0;
      x      <= '0;
      y      <= '0;
      loaded <= 1'b0;
    end else if (clear) begin
      // Operand contents are kept; the next load simply overwrites them.
      state  <= LOAD_X;
      r      <= '0;
      c      <= '0;
      count  <= '0;
      loaded <= 1'b0;
    end else if (in_valid && state != FULL) begin
      if (state == LOAD_X) x[M*idx +: M] <= in_data;
      else                 y[M*idx +: M] <= in_data;
      count <= count + CW'(1);
      if (c == LAST) begin
        c <= '0;
        if (r == LAST) begin
          r <= '0;
          if (state == LOAD_X) begin
            state <= LOAD_Y;
          end else begin
            state  <= FULL;
            loaded <= 1'b1;
          end
        end else begin
          r <= r + RW'(1);
        end
      end else begin
        c <= c + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_load_seq.sv
// Directed bench for matrix_load_seq: an N=3 instance for the main scenarios and
// an N=1 instance for the degenerate size.
module tb_matrix_load_seq;

  logic         clk;
  logic         rst;

  logic [31:0]  a_data;
  logic         a_valid;
  logic         a_ready;
  logic         a_clear;
  logic [287:0] a_x;
  logic [287:0] a_y;
  logic         a_loaded;
  logic [4:0]   a_count;

  logic [31:0]  b_data;
  logic         b_valid;
  logic         b_ready;
  logic         b_clear;
  logic [31:0]  b_x;
  logic [31:0]  b_y;
  logic         b_loaded;
  logic [1:0]   b_count;

  int checks;
  int errors;

  matrix_load_seq #(.N(3), .M(32)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .clear(a_clear), .x(a_x), .y(a_y), .loaded(a_loaded), .count(a_count)
  );

  matrix_load_seq #(.N(1), .M(32)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .clear(b_clear), .x(b_x), .y(b_y), .loaded(b_loaded), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] xe(input int i);
    return a_x[32*i +: 32];
  endfunction

  function automatic logic [31:0] ye(input int i);
    return a_y[32*i +: 32];
  endfunction

  // Drive one offer for a single edge, then sample 1 time unit after it.
  task automatic offer_a(input logic [31:0] d);
    a_data  = d;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic idle_a();
    @(posedge clk); #1;
  endtask

  task automatic clear_a();
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    a_data  = '0; a_valid = 1'b0; a_clear = 1'b0;
    b_data  = '0; b_valid = 1'b0; b_clear = 1'b0;

    #3;
    check_val("rst_ready", 64'(a_ready), 64'd0);
    check_val("rst_count", 64'(a_count), 64'd0);
    check_val("rst_loaded", 64'(a_loaded), 64'd0);
    check_val("rst_x_zero", 64'(|a_x), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_a();
    check_val("ready_after_rst", 64'(a_ready), 64'd1);

    // Back-to-back stream 1..18
    for (int i = 1; i <= 18; i++) begin
      offer_a(32'(i));
      if (i == 1) begin
        check_val("first_x00", 64'(xe(0)), 64'd1);
        check_val("first_count", 64'(a_count), 64'd1);
      end
      if (i == 9) check_val("x_done_ready", 64'(a_ready), 64'd1);
      if (i == 17) begin
        check_val("pre_last_loaded", 64'(a_loaded), 64'd0);
        check_val("pre_last_count", 64'(a_count), 64'd17);
      end
    end
    check_val("b2b_loaded", 64'(a_loaded), 64'd1);
    check_val("b2b_count", 64'(a_count), 64'd18);
    check_val("b2b_ready", 64'(a_ready), 64'd0);
    check_val("b2b_x00", 64'(xe(0)), 64'd1);
    check_val("b2b_x22", 64'(xe(8)), 64'd9);
    check_val("b2b_y00", 64'(ye(0)), 64'd10);
    check_val("b2b_y22", 64'(ye(8)), 64'd18);

    // Clear keeps contents, then bubbled stream plus offers while FULL
    clear_a();
    check_val("clr_count", 64'(a_count), 64'd0);
    check_val("clr_loaded", 64'(a_loaded), 64'd0);
    check_val("clr_ready", 64'(a_ready), 64'd1);
    check_val("clr_x_kept", 64'(xe(0)), 64'd1);
    for (int i = 1; i <= 18; i++) begin
      offer_a(32'h200 + 32'(i));
      idle_a();
    end
    check_val("gap_count", 64'(a_count), 64'd18);
    check_val("gap_loaded", 64'(a_loaded), 64'd1);
    for (int i = 0; i < 5; i++) offer_a(32'hDEAD);
    check_val("full_count", 64'(a_count), 64'd18);
    check_val("full_loaded", 64'(a_loaded), 64'd1);
    check_val("full_x00", 64'(xe(0)), 64'h201);
    check_val("full_x11", 64'(xe(4)), 64'h205);
    check_val("full_y00", 64'(ye(0)), 64'h20A);
    check_val("full_y22", 64'(ye(8)), 64'h212);

    // Clear mid-load
    clear_a();
    for (int i = 0; i < 7; i++) offer_a(32'hA0 + 32'(i));
    check_val("mid_count", 64'(a_count), 64'd7);
    check_val("mid_x20", 64'(xe(6)), 64'hA6);
    clear_a();
    check_val("mid_clr_count", 64'(a_count), 64'd0);
    for (int i = 1; i <= 18; i++) begin
      offer_a(32'(i));
      if (i == 17) check_val("mid_pre_loaded", 64'(a_loaded), 64'd0);
    end
    check_val("mid_loaded", 64'(a_loaded), 64'd1);
    check_val("mid_x00", 64'(xe(0)), 64'd1);
    check_val("mid_x20b", 64'(xe(6)), 64'd7);
    check_val("mid_y22", 64'(ye(8)), 64'd18);

    // Clear coinciding with the final offer drops that element
    clear_a();
    for (int i = 1; i <= 17; i++) offer_a(32'h300 + 32'(i));
    check_val("fin_count17", 64'(a_count), 64'd17);
    a_clear = 1'b1;
    offer_a(32'h312);
    a_clear = 1'b0;
    check_val("fin_count", 64'(a_count), 64'd0);
    check_val("fin_loaded", 64'(a_loaded), 64'd0);
    check_val("fin_ready", 64'(a_ready), 64'd1);
    check_val("fin_y21", 64'(ye(7)), 64'h311);
    check_val("fin_y22_kept", 64'(ye(8)), 64'd18);
    offer_a(32'h55);
    check_val("fin_restart_x00", 64'(xe(0)), 64'h55);

    // Asynchronous reset mid-load, asserted between edges
    clear_a();
    for (int i = 1; i <= 12; i++) offer_a(32'h400 + 32'(i));
    check_val("arst_pre_count", 64'(a_count), 64'd12);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_count", 64'(a_count), 64'd0);
    check_val("arst_x", 64'(|a_x), 64'd0);
    check_val("arst_y", 64'(|a_y), 64'd0);
    check_val("arst_loaded", 64'(a_loaded), 64'd0);
    check_val("arst_ready", 64'(a_ready), 64'd0);
    idle_a();
    check_val("arst_ready_held", 64'(a_ready), 64'd0);
    rst = 1'b1;
    idle_a();
    check_val("arst_ready_rel", 64'(a_ready), 64'd1);

    // N=1 instance
    b_data = 32'd5; b_valid = 1'b1;
    @(posedge clk); #1;
    check_val("n1_x", 64'(b_x), 64'd5);
    check_val("n1_count1", 64'(b_count), 64'd1);
    check_val("n1_loaded0", 64'(b_loaded), 64'd0);
    b_data = 32'd7;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check_val("n1_y", 64'(b_y), 64'd7);
    check_val("n1_loaded", 64'(b_loaded), 64'd1);
    check_val("n1_count", 64'(b_count), 64'd2);
    check_val("n1_ready", 64'(b_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
